// File: rtl/wb_sram_slave.sv
// Wishbone B4 registered-feedback memory target.
// Word-addressed RAM with byte enables. Serves classic single cycles and
// incrementing bursts (linear, 4/8/16-beat wrap).
module wb_sram_slave #(
   parameter int unsigned WB_ADDR_WIDTH = 32,
   parameter int unsigned WB_DATA_WIDTH = 32,
   parameter int unsigned MEM_ADDR_BITS = 10,
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WB_ADDR_WIDTH-1:0]   s_adr_i,
   input  logic [WB_DATA_WIDTH-1:0]   s_dat_w_i,
   input  logic [WB_DATA_WIDTH/8-1:0] s_sel_i,
   input  logic                       s_cyc_i,
   input  logic                       s_stb_i,
   input  logic                       s_we_i,
   input  logic [2:0]                 s_cti_i,
   input  logic [1:0]                 s_bte_i,
   output logic [WB_DATA_WIDTH-1:0]   s_dat_r_o,
   output logic                       s_ack_o,
   output logic                       s_err_o
);

   localparam int unsigned NumBytes    = WB_DATA_WIDTH / 8;
   localparam int unsigned ByteShift   = $clog2(NumBytes);
   localparam int unsigned RamAddrBits = MEM_ADDR_BITS + ByteShift;
   localparam int unsigned Depth       = 2 ** MEM_ADDR_BITS;

   typedef enum logic [1:0] {StIdle, StSingle, StBurst} state_e;

   state_e                   state_q, state_d;
   logic [MEM_ADDR_BITS-1:0] cnt_q, cnt_d;
   logic                     oor_q, oor_d;
   logic [WB_DATA_WIDTH-1:0] mem_q [Depth];

   logic                     beat;
   logic                     mem_we;
   logic [WB_ADDR_WIDTH-1:0] offset;
   logic                     adr_in_range;
   logic [MEM_ADDR_BITS-1:0] wrap_mask;
   logic [MEM_ADDR_BITS-1:0] cnt_inc;
   logic [MEM_ADDR_BITS-1:0] cnt_adv;
   logic                     oor_adv;

   assign beat = s_cyc_i & s_stb_i;

   // BASE_ADDR is aligned to the RAM size, so any offset with bits above the RAM
   // span set is outside the window.
   assign offset       = s_adr_i - BASE_ADDR;
   assign adr_in_range = (s_adr_i >= BASE_ADDR) && ((offset >> RamAddrBits) == '0);

   // Burst address advance: the mask selects which low bits of cnt count.
   always_comb begin
      wrap_mask = '1;
      case (s_bte_i)
         2'b01:   wrap_mask = MEM_ADDR_BITS'(3);
         2'b10:   wrap_mask = MEM_ADDR_BITS'(7);
         2'b11:   wrap_mask = MEM_ADDR_BITS'(15);
         default: wrap_mask = '1;
      endcase
      cnt_inc = cnt_q + MEM_ADDR_BITS'(1);
      cnt_adv = (cnt_q & ~wrap_mask) | (cnt_inc & wrap_mask);
      // A linear step past the top word leaves the window and stays out.
      oor_adv = oor_q | ((s_bte_i == 2'b00) && (cnt_q == '1));
   end

   // State, word counter and range flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oor_q   <= oor_d;
      end
   end

   // Next-state logic: latch the cycle on start, advance cnt on burst beats.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oor_d   = oor_q;
      case (state_q)
         StIdle: begin
            if (beat) begin
               cnt_d   = s_adr_i[RamAddrBits-1:ByteShift];
               oor_d   = !adr_in_range;
               state_d = (s_cti_i == 3'b010) ? StBurst : StSingle;
            end
         end
         StSingle: begin
            state_d = StIdle;
         end
         StBurst: begin
            if (!s_cyc_i) begin
               state_d = StIdle;
            end else if (s_stb_i) begin
               cnt_d = cnt_adv;
               oor_d = oor_adv;
               // Anything but "incrementing" ends the burst after this beat.
               if (s_cti_i != 3'b010) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Response outputs; nothing is driven during reset so that cycle never writes.
   always_comb begin
      s_ack_o = 1'b0;
      s_err_o = 1'b0;
      if (!rst && beat && (state_q == StSingle || state_q == StBurst)) begin
         s_ack_o = !oor_q;
         s_err_o = oor_q;
      end
      mem_we    = s_ack_o & s_we_i;
      s_dat_r_o = s_ack_o ? mem_q[cnt_q] : '0;
   end

   // RAM write with byte lanes; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (s_sel_i[b]) begin
               mem_q[cnt_q][8*b +: 8] <= s_dat_w_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: table of single cycles, hand-written
// burst and reset sequences, response scoreboard checked by a bus monitor.
module tb_wb_sram_slave;

   localparam logic [31:0] Base = 32'h1000_0000;
   localparam logic [31:0] Sz   = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        cyc, stb, we;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_r;
   logic        ack, err;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        ack;
      logic        err;
      logic        chk;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      logic        ack;
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[16];
   logic [31:0] bdat[16];
   logic        berr[16];

   wb_sram_slave #(
      .WB_ADDR_WIDTH(32),
      .WB_DATA_WIDTH(32),
      .MEM_ADDR_BITS(10),
      .BASE_ADDR    (Base)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_adr_i  (adr),
      .s_dat_w_i(dat_w),
      .s_sel_i  (sel),
      .s_cyc_i  (cyc),
      .s_stb_i  (stb),
      .s_we_i   (we),
      .s_cti_i  (cti),
      .s_bte_i  (bte),
      .s_dat_r_o(dat_r),
      .s_ack_o  (ack),
      .s_err_o  (err)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic a_we, input logic [31:0] a_adr, input logic [31:0] a_dat,
                              input logic [3:0] a_sel, input logic a_err, input logic [31:0] a_rd);
      vec_t r;
      r.we  = a_we;
      r.adr = a_adr;
      r.dat = a_dat;
      r.sel = a_sel;
      r.ack = !a_err;
      r.err = a_err;
      r.chk = !a_we || a_err;
      r.rd  = a_err ? 32'h0 : a_rd;
      return r;
   endfunction

   task automatic push_exp(input logic a_ack, input logic a_err, input logic a_chk,
                           input logic [31:0] a_dat);
      exp_t e;
      e.ack = a_ack;
      e.err = a_err;
      e.chk = a_chk;
      e.dat = a_dat;
      sb.push_back(e);
   endtask

   // Bus monitor: every response is matched against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check32("rst_no_resp", 32'({ack, err}), 32'h0);
      end else if (ack || err) begin
         check32("ack_err_excl", 32'(ack & err), 32'h0);
         check32("resp_needs_cyc", 32'(cyc), 32'h1);
         if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL sb_unexpected: got ack=%0b err=%0b, want no response", ack, err);
         end else begin
            e = sb.pop_front();
            check32("sb_resp", 32'({ack, err}), 32'({e.ack, e.err}));
            if (e.chk) check32("sb_data", dat_r, e.dat);
         end
      end else begin
         check32("dat_r_idle", dat_r, 32'h0);
      end
   end

   task automatic wb_single(input string name, input vec_t t);
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = t.we; adr = t.adr; dat_w = t.dat; sel = t.sel;
      cti = 3'b000; bte = 2'b00;
      push_exp(t.ack, t.err, t.chk, t.rd);
      @(negedge clk);
      check32({name, "_pre"}, 32'({ack, err}), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check32({name, "_resp"}, 32'({ack, err}), 32'({t.ack, t.err}));
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check32({name, "_one_cycle"}, 32'({ack, err}), 32'h0);
   endtask

   task automatic read_word(input string name, input logic [31:0] a_adr, input logic [31:0] exp);
      wb_single(name, v(1'b0, a_adr, 32'h0, 4'hF, 1'b0, exp));
   endtask

   // Burst of n beats using bdat/berr; STB drops for two cycles after beat hold_after.
   task automatic wb_burst(input string name, input logic a_we, input logic [31:0] a_adr,
                           input logic [1:0] a_bte, input int n, input int hold_after);
      int acks = 0;
      int exp_acks = 0;
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = a_we; adr = a_adr; bte = a_bte; cti = 3'b010;
      dat_w = bdat[0]; sel = 4'hF;
      for (int i = 0; i < n; i++) begin
         push_exp(!berr[i], berr[i], !a_we || berr[i], berr[i] ? 32'h0 : bdat[i]);
         if (!berr[i]) exp_acks++;
         if (i == 0) @(posedge clk);
         @(negedge clk);
         if (ack) acks++;
         check32({name, "_beat"}, 32'({ack, err}), 32'({!berr[i], berr[i]}));
         @(posedge clk);
         #1;
         if (i == hold_after) begin
            stb = 1'b0;
            repeat (2) begin
               @(negedge clk);
               check32({name, "_hold"}, 32'({ack, err}), 32'h0);
               @(posedge clk);
               #1;
            end
            stb = 1'b1;
         end
         if (i + 1 < n) begin
            dat_w = bdat[i+1];
            adr   = ~a_adr;
            cti   = (i + 1 == n - 1) ? 3'b111 : 3'b010;
         end else begin
            cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
         end
      end
      check32({name, "_ack_count"}, 32'(acks), 32'(exp_acks));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
      cti = '0; bte = '0;

      vecs[0]  = v(1'b1, Base + 32'h10, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0);
      vecs[1]  = v(1'b0, Base + 32'h10, 32'h0,         4'hF,    1'b0, 32'hDEAD_BEEF);
      vecs[2]  = v(1'b1, Base + 32'h10, 32'h0000_AB00, 4'b0010, 1'b0, 32'h0);
      vecs[3]  = v(1'b0, Base + 32'h10, 32'h0,         4'hF,    1'b0, 32'hDEAD_ABEF);
      vecs[4]  = v(1'b1, Base + 32'h20, 32'h1122_3344, 4'hF,    1'b0, 32'h0);
      vecs[5]  = v(1'b1, Base + 32'h20, 32'hAABB_CCDD, 4'b1001, 1'b0, 32'h0);
      vecs[6]  = v(1'b0, Base + 32'h20, 32'h0,         4'hF,    1'b0, 32'hAA22_33DD);
      vecs[7]  = v(1'b1, Base + 32'h10, 32'h4,         4'hF,    1'b0, 32'h0);
      vecs[8]  = v(1'b1, Base + 32'h14, 32'h5,         4'hF,    1'b0, 32'h0);
      vecs[9]  = v(1'b1, Base + 32'h18, 32'h6,         4'hF,    1'b0, 32'h0);
      vecs[10] = v(1'b1, Base + 32'h1C, 32'h7,         4'hF,    1'b0, 32'h0);
      vecs[11] = v(1'b1, Base + 32'h00, 32'h5A5A_0000, 4'hF,    1'b0, 32'h0);
      vecs[12] = v(1'b1, Base + 32'h88, 32'h3333_3333, 4'hF,    1'b0, 32'h0);
      vecs[13] = v(1'b0, Base + Sz,     32'h0,         4'hF,    1'b1, 32'h0);
      vecs[14] = v(1'b0, Base - 32'h4,  32'h0,         4'hF,    1'b1, 32'h0);
      vecs[15] = v(1'b1, Base + Sz,     32'hFFFF_FFFF, 4'hF,    1'b1, 32'h0);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check32("reset_ack_err", 32'({ack, err}), 32'h0);
      check32("reset_dat_r", dat_r, 32'h0);

      for (int k = 0; k < 16; k++) begin
         wb_single($sformatf("vec%0d", k), vecs[k]);
      end

      // 4-beat wrap read starting at word 6.
      bdat[0] = 32'h6; bdat[1] = 32'h7; bdat[2] = 32'h4; bdat[3] = 32'h5;
      for (int i = 0; i < 16; i++) berr[i] = 1'b0;
      wb_burst("wrap4_rd", 1'b0, Base + 32'h18, 2'b01, 4, -1);
      read_word("after_wrap", Base + 32'h1C, 32'h7);

      // Linear 16-beat write with an STB hold after beat 5, then read back.
      for (int i = 0; i < 16; i++) bdat[i] = 32'hA000_0000 + 32'(i);
      wb_burst("lin16_wr", 1'b1, Base + 32'h400, 2'b00, 16, 4);
      wb_burst("lin16_rd", 1'b0, Base + 32'h400, 2'b00, 16, -1);

      // Linear burst from the top word runs off the end on beat 2.
      bdat[0] = 32'h0BAD_0001; bdat[1] = 32'h0BAD_0002;
      berr[1] = 1'b1;
      wb_burst("lin_oor", 1'b1, Base + Sz - 32'h4, 2'b00, 2, -1);
      berr[1] = 1'b0;
      read_word("top_word", Base + Sz - 32'h4, 32'h0BAD_0001);
      read_word("word0_untouched", Base, 32'h5A5A_0000);

      // Reset lands on beat 3 of an 8-beat wrap write.
      @(posedge clk);
      #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = Base + 32'h80; cti = 3'b010; bte = 2'b10;
      sel = 4'hF; dat_w = 32'hC0;
      push_exp(1'b1, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check32("rstb_beat1", 32'({ack, err}), 32'h2);
      @(posedge clk);
      #1;
      dat_w = 32'hC1;
      push_exp(1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check32("rstb_beat2", 32'({ack, err}), 32'h2);
      @(posedge clk);
      #1;
      dat_w = 32'hC2;
      rst = 1'b1;
      @(negedge clk);
      check32("rstb_beat3_in_reset", 32'({ack, err}), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
      @(negedge clk);
      check32("rstb_after_reset", 32'({ack, err}), 32'h0);
      read_word("rstb_word0", Base + 32'h80, 32'hC0);
      read_word("rstb_word1", Base + 32'h84, 32'hC1);
      read_word("rstb_word2", Base + 32'h88, 32'h3333_3333);

      repeat (2) @(posedge clk);
      check32("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
